// File: rtl/n_stages_axis_frame_source.sv
// Buffered frame source: samples are loaded into a local RAM while idle, then
// replayed as one AXI-Stream frame toward the FIR input on each start request.
module n_stages_axis_frame_source #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         start,
  input  logic [ADDR_W:0]              frame_len,
  output logic                         busy,
  output logic                         done,
  output logic signed [DATA_WIDTH-1:0] m_axis_fir_tdata,
  output logic                         m_axis_fir_tvalid,
  input  logic                         m_axis_fir_tready,
  output logic                         m_axis_fir_tlast
);

  typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DONE} state_t;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_W-1:0]            rd_idx;
  logic [ADDR_W:0]              len_q;
  logic [ADDR_W:0]              beat_cnt;
  logic                         launch;
  logic                         accept;
  logic                         load;
  logic                         rd_en;

  assign launch = (state == IDLE) && start && (frame_len != '0);
  assign accept = m_axis_fir_tvalid && m_axis_fir_tready;
  // The output register refills whenever it is empty or being drained, so the
  // read-ahead word in rd_data keeps the stream bubble-free at full rate.
  assign load   = (state == STREAM) && (!m_axis_fir_tvalid || m_axis_fir_tready)
                  && (beat_cnt < len_q);
  assign rd_en  = (state == PREFETCH) || load;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned,
  // which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (launch) state_nxt = PREFETCH;
      PREFETCH: state_nxt = STREAM;
      STREAM:   if (accept && m_axis_fir_tlast) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q             <= '0;
      beat_cnt          <= '0;
      rd_idx            <= '0;
      m_axis_fir_tdata  <= '0;
      m_axis_fir_tvalid <= 1'b0;
      m_axis_fir_tlast  <= 1'b0;
    end else begin
      if (launch) begin
        len_q    <= (frame_len > LEN_MAX) ? LEN_MAX : frame_len;
        beat_cnt <= '0;
        rd_idx   <= '0;
      end
      if (rd_en) rd_idx <= rd_idx + ADDR_W'(1);
      if (load) begin
        m_axis_fir_tdata  <= rd_data;
        m_axis_fir_tvalid <= 1'b1;
        m_axis_fir_tlast  <= (beat_cnt + LEN_ONE == len_q);
        beat_cnt          <= beat_cnt + LEN_ONE;
      end else if (accept) begin
        m_axis_fir_tvalid <= 1'b0;
        m_axis_fir_tlast  <= 1'b0;
      end
    end
  end

  // NOTE: the sample RAM and its read register carry no reset so the buffer
  // survives reset and maps onto plain block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: tb/tb_n_stages_axis_frame_source.sv
// Directed bench for n_stages_axis_frame_source: frame replay, back-pressure,
// length clamping, ignored requests, mid-frame reset and back-to-back frames.
module tb_n_stages_axis_frame_source;

  logic               clk = 1'b0;
  logic               reset;
  logic               wr_en;
  logic [5:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               start;
  logic [6:0]         frame_len;
  logic               busy;
  logic               done;
  logic signed [15:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;

  logic signed [15:0] model [64];
  int n_checks = 0;
  int n_fail   = 0;

  n_stages_axis_frame_source dut (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .start             (start),
    .frame_len         (frame_len),
    .busy              (busy),
    .done              (done),
    .m_axis_fir_tdata  (tdata),
    .m_axis_fir_tvalid (tvalid),
    .m_axis_fir_tready (tready),
    .m_axis_fir_tlast  (tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] addr, input logic signed [15:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
    model[addr] = data;
  endtask

  task automatic launch(input logic [6:0] len);
    frame_len = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Called one cycle after the start edge; consumes the whole frame and the
  // done cycle, optionally stalling (tready 1,0,0,...) and injecting requests.
  task automatic stream_frame(input string tag, input int n, input bit toggle,
                              input bit inject);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic signed [15:0] prev_d = '0;
    logic prev_l = 1'b0;
    tready = 1'b1;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_lat1"}, tvalid, 0);
    step();
    check({tag, "_lat2"}, tvalid, 0);
    step();
    check({tag, "_rise"}, tvalid, 1);
    while (k < n && cyc < 4 * n + 10) begin
      tready = toggle ? (cyc % 3 == 0) : 1'b1;
      start     = inject && (cyc == 2);
      wr_en     = inject && (cyc == 2);
      frame_len = 7'd5;
      wr_addr   = 6'd1;
      wr_data   = 16'sd999;
      check({tag, "_valid"}, tvalid, 1);
      if (stalled) begin
        check({tag, "_hold_d"}, tdata, prev_d);
        check({tag, "_hold_l"}, tlast, prev_l);
      end
      if (tvalid && tready) begin
        check({tag, "_data"}, tdata, model[k]);
        check({tag, "_last"}, tlast, (k == n - 1) ? 1 : 0);
        k++;
        stalled = 1'b0;
      end else if (tvalid) begin
        stalled = 1'b1;
        prev_d  = tdata;
        prev_l  = tlast;
      end
      cyc++;
      step();
    end
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, "_handshakes"}, k, n);
    if (!toggle) check({tag, "_cycles"}, cyc, n);
    check({tag, "_fall"}, tvalid, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_done"}, busy, 1);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; frame_len = '0; tready = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", tvalid, 0);
    check("rst_last", tlast, 0);
    check("rst_data", tdata, 0);
    step();
    step();
    reset = 1'b1;

    // Basic frame at full rate
    do_write(6'd0, 16'sd10);
    do_write(6'd1, -16'sd20);
    do_write(6'd2, 16'sd30);
    do_write(6'd3, -16'sd40);
    launch(7'd4);
    stream_frame("basic", 4, 1'b0, 1'b0);

    // Same frame under back-pressure
    launch(7'd4);
    stream_frame("stall", 4, 1'b1, 1'b0);

    // Zero-length start is ignored
    frame_len = 7'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("len0_busy", busy, 0);
    step();
    check("len0_valid", tvalid, 0);
    step();
    check("len0_done", done, 0);
    check("len0_valid2", tvalid, 0);

    // start and wr_en mid-frame are ignored; buffer replays unchanged
    launch(7'd4);
    stream_frame("inject", 4, 1'b0, 1'b1);
    step();
    check("inject_idle_valid", tvalid, 0);
    check("inject_idle_busy", busy, 0);
    launch(7'd4);
    stream_frame("replay", 4, 1'b0, 1'b0);

    // Reset mid-frame after beats 0..2 are accepted
    do_write(6'd4, 16'sd50);
    do_write(6'd5, -16'sd60);
    do_write(6'd6, 16'sd70);
    do_write(6'd7, -16'sd80);
    launch(7'd8);
    tready = 1'b1;
    step();
    step();
    check("abort_first", tdata, 10);
    step();
    step();
    step();
    check("abort_beat3", tdata, -40);
    #2 reset = 1'b0;
    #1;
    check("abort_valid", tvalid, 0);
    check("abort_last", tlast, 0);
    check("abort_busy", busy, 0);
    check("abort_data", tdata, 0);
    step();
    step();
    check("abort_done", done, 0);
    reset = 1'b1;
    launch(7'd8);
    stream_frame("restart", 8, 1'b0, 1'b0);

    // Back-to-back single-beat frames
    launch(7'd1);
    stream_frame("single_a", 1, 1'b0, 1'b0);
    launch(7'd1);
    stream_frame("single_b", 1, 1'b0, 1'b0);

    // Oversized length clamps to DEPTH
    for (int i = 8; i < 64; i++) do_write(6'(i), 16'(i * 7 - 200));
    launch(7'd65);
    stream_frame("clamp", 64, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n_stages_axis_frame_source.md
N_STAGES_AXIS_FRAME_SOURCE -- requirements
Module: n_stages_axis_frame_source

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 Parameter DEPTH, default 64, sample buffer entries (power of two).
REQ-003 Parameter ADDR_W, default 6, buffer address width, equal to log2(DEPTH).
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port wr_en  input  1  buffer write strobe.
REQ-007 Port wr_addr  input  ADDR_W  buffer write address.
REQ-008 Port wr_data  input  DATA_WIDTH (signed)  buffer write data.
REQ-009 Port start  input  1  single-cycle frame launch request.
REQ-010 Port frame_len  input  ADDR_W+1  number of samples in the frame, sampled with start.
REQ-011 Port busy  output  1  frame in progress.
REQ-012 Port done  output  1  single-cycle pulse after the last beat is accepted.
REQ-013 Port m_axis_fir_tdata  output  DATA_WIDTH (signed)  AXI-Stream master data, driving the FIR slave input.
REQ-014 Port m_axis_fir_tvalid  output  1  AXI-Stream valid.
REQ-015 Port m_axis_fir_tready  input  1  AXI-Stream ready from the FIR.
REQ-016 Port m_axis_fir_tlast  output  1  AXI-Stream last, marking the final frame sample.

Function
REQ-017 The FSM SHALL have the states IDLE, PREFETCH, STREAM and DONE.
REQ-018 In IDLE with wr_en=1, the block SHALL write wr_data to buffer[wr_addr] on the clock edge; wr_en SHALL be ignored in every other state.
REQ-019 In IDLE with start=1 and frame_len in 1..DEPTH, the block SHALL latch frame_len, clear the read index to 0 and enter PREFETCH.
REQ-020 frame_len > DEPTH SHALL be clamped to DEPTH; start with frame_len=0 SHALL be ignored (stay in IDLE, no done).
REQ-021 start in any state other than IDLE SHALL be ignored.
REQ-022 Buffer read SHALL be synchronous with one-cycle latency; PREFETCH SHALL last exactly one cycle and then enter STREAM.
REQ-023 m_axis_fir_tvalid SHALL rise exactly 2 cycles after the edge that samples start, carrying buffer[0].
REQ-024 A beat SHALL transfer on any edge where tvalid=1 and tready=1.
REQ-025 While tvalid=1 and tready=0, tdata, tvalid and tlast SHALL hold stable.
REQ-026 tvalid SHALL NOT depend combinationally on tready.
REQ-027 The source SHALL sustain one beat per cycle while tready=1; there SHALL be no bubbles between beats of a frame.
REQ-028 Beat k (0-based) SHALL carry buffer[k]; tlast SHALL be 1 only on beat frame_len-1.
REQ-029 A frame_len=1 frame SHALL present a single beat with tlast=1.
REQ-030 On acceptance of the tlast beat, tvalid SHALL fall on the same edge, and the FSM SHALL enter DONE.
REQ-031 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-032 busy SHALL be 1 in PREFETCH, STREAM and DONE, and 0 in IDLE.
REQ-033 A start asserted in the cycle after DONE SHALL be accepted, giving back-to-back frames.
REQ-034 Buffer contents SHALL persist across frames.

Reset
REQ-035 reset=0 SHALL immediately force IDLE, busy=0, done=0, tvalid=0, tlast=0 and tdata=0, independent of clk.
REQ-036 Reset mid-frame SHALL abort the frame with no tlast and no done.
REQ-037 The buffer SHALL NOT be cleared by reset.
REQ-038 After reset deasserts, the block SHALL accept writes and start on the first rising edge.

Verification
REQ-039 Load buffer[0..3] with 10, -20, 30, -40; start with frame_len=4 and tready=1 -> beats 10, -20, 30, -40 on 4 consecutive cycles, tlast on -40, done one cycle later.
REQ-040 Same frame with tready toggling 1,0,0,1,... -> identical beat sequence, tdata stable during every stall, and exactly 4 handshakes.
REQ-041 frame_len=0 start -> no tvalid, busy stays 0; frame_len=DEPTH+1 -> exactly DEPTH beats, tlast on buffer[DEPTH-1].
REQ-042 start and wr_en pulsed mid-frame -> both ignored; output sequence and buffer unchanged.
REQ-043 reset=0 asserted after beat 2 of an 8-beat frame -> tvalid=0 immediately, no done; a restart after reset replays from buffer[0].
REQ-044 frame_len=1 followed by start in the cycle after done -> two single-beat frames, each with tlast=1 and its own done pulse.
